// File: rtl/gpu_pkg.sv
// Shared sparkbox GPU definitions: default frame geometry, sweep FSM states and
// the sweep token layout consumed by the header pipe.
package gpu_pkg;

    localparam int unsigned H_ACTIVE_DEF   = 1280;
    localparam int unsigned V_ACTIVE_DEF   = 720;
    localparam int unsigned NUM_LAYERS_DEF = 8;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned X_W_DEF = cnt_w(H_ACTIVE_DEF);
    localparam int unsigned Y_W_DEF = cnt_w(V_ACTIVE_DEF);
    localparam int unsigned L_W_DEF = cnt_w(NUM_LAYERS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic [L_W_DEF-1:0] layer;
        logic               first_layer;
        logic               last_layer;
        logic               last_pixel;
    } sweep_token_t;

endpackage

// File: rtl/pixel_layer_sweep_if.sv
// Sweep token stream (valid/ready) from the pixel/layer sweep to the header stage.
interface pixel_layer_sweep_if
    import gpu_pkg::*;
#(
    parameter int unsigned X_W = X_W_DEF,
    parameter int unsigned Y_W = Y_W_DEF,
    parameter int unsigned L_W = L_W_DEF
);
    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [L_W-1:0] out_layer;
    logic           out_first_layer;
    logic           out_last_layer;
    logic           out_last_pixel;

    modport master (
        output out_valid, out_x, out_y, out_layer,
               out_first_layer, out_last_layer, out_last_pixel,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_x, out_y, out_layer,
               out_first_layer, out_last_layer, out_last_pixel,
        output out_ready
    );
endinterface

// File: rtl/gpu_wrap_counter.sv
// Modulus counter with enable, synchronous clear and terminal-count output.
// count_step is the value the counter takes on its next enabled step.
module gpu_wrap_counter #(
    parameter int unsigned MODULUS = 2,
    parameter int unsigned W       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_step,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    assign tc         = (count == LAST);
    assign count_step = tc ? '0 : count + W'(1);

    // Count register: clear wins over enable; wraps to zero after LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_step;
        end
    end
endmodule

// File: rtl/pixel_layer_sweep.sv
// Pixel/layer sweep: on frame_go walks every (x, y, layer) of one frame, layer
// innermost, as a valid/ready token stream, then pulses frame_done once.
module pixel_layer_sweep
    import gpu_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int unsigned X_W        = cnt_w(H_ACTIVE),
    parameter int unsigned Y_W        = cnt_w(V_ACTIVE),
    parameter int unsigned L_W        = cnt_w(NUM_LAYERS)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                frame_go,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    pixel_layer_sweep_if.master tok
);
    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);
    localparam logic [L_W-1:0] L_MAX = L_W'(NUM_LAYERS - 1);

    sweep_state_t   state_q, state_d;

    logic [X_W-1:0] x_cnt, x_step, x_nxt;
    logic [Y_W-1:0] y_cnt, y_step, y_nxt;
    logic [L_W-1:0] l_cnt, l_step, l_nxt;
    logic           x_tc, y_tc, l_tc;
    logic           start, adv, x_en, y_en, frame_end;
    logic           first_q, last_l_q, last_p_q;

    assign start     = (state_q == IDLE) && frame_go;
    assign adv       = (state_q == RUN) && tok.out_ready;
    assign x_en      = adv && l_tc;
    assign y_en      = x_en && x_tc;
    assign frame_end = y_en && y_tc;

    gpu_wrap_counter #(.MODULUS(NUM_LAYERS), .W(L_W)) u_layer (
        .clk(clk_in), .rst(reset_in), .clr(start), .en(adv),
        .count(l_cnt), .count_step(l_step), .tc(l_tc)
    );

    gpu_wrap_counter #(.MODULUS(H_ACTIVE), .W(X_W)) u_x (
        .clk(clk_in), .rst(reset_in), .clr(start), .en(x_en),
        .count(x_cnt), .count_step(x_step), .tc(x_tc)
    );

    gpu_wrap_counter #(.MODULUS(V_ACTIVE), .W(Y_W)) u_y (
        .clk(clk_in), .rst(reset_in), .clr(start), .en(y_en),
        .count(y_cnt), .count_step(y_step), .tc(y_tc)
    );

    // Coordinates of the token that follows the current one, used to register flags.
    always_comb begin
        l_nxt = l_step;
        x_nxt = l_tc ? x_step : x_cnt;
        y_nxt = (l_tc && x_tc) ? y_step : y_cnt;
    end

    // State register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frame_go only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_go)  state_d = RUN;
            RUN:     if (frame_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy          = (state_q == RUN);
        tok.out_valid = (state_q == RUN);
        frame_done    = (state_q == DONE);
    end

    // Token flags are loaded together with the coordinates they describe, so they
    // stay stable under backpressure; frame_count bumps on the final handshake.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            first_q     <= 1'b0;
            last_l_q    <= 1'b0;
            last_p_q    <= 1'b0;
            frame_count <= '0;
        end else if (start) begin
            first_q  <= 1'b1;
            last_l_q <= (L_MAX == '0);
            last_p_q <= (L_MAX == '0) && (X_MAX == '0) && (Y_MAX == '0);
        end else if (frame_end) begin
            first_q     <= 1'b0;
            last_l_q    <= 1'b0;
            last_p_q    <= 1'b0;
            frame_count <= frame_count + 16'd1;
        end else if (adv) begin
            first_q  <= (l_nxt == '0);
            last_l_q <= (l_nxt == L_MAX);
            last_p_q <= (l_nxt == L_MAX) && (x_nxt == X_MAX) && (y_nxt == Y_MAX);
        end
    end

    assign tok.out_x           = x_cnt;
    assign tok.out_y           = y_cnt;
    assign tok.out_layer       = l_cnt;
    assign tok.out_first_layer = first_q;
    assign tok.out_last_layer  = last_l_q;
    assign tok.out_last_pixel  = last_p_q;
endmodule

// File: tb/tb_pixel_layer_sweep.sv
// Directed bench for pixel_layer_sweep: a 4x3x2 instance for the main scenarios
// and a 2x2x1 instance for the single-layer case.
module tb_pixel_layer_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        go_a, go_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] cnt_a, cnt_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    pixel_layer_sweep_if #(.X_W(2), .Y_W(2), .L_W(1)) if_a ();
    pixel_layer_sweep_if #(.X_W(1), .Y_W(1), .L_W(1)) if_b ();

    pixel_layer_sweep #(
        .H_ACTIVE(4), .V_ACTIVE(3), .NUM_LAYERS(2), .X_W(2), .Y_W(2), .L_W(1)
    ) dut_a (
        .clk_in(clk), .reset_in(rst), .frame_go(go_a), .busy(busy_a),
        .frame_done(done_a), .frame_count(cnt_a), .tok(if_a)
    );

    pixel_layer_sweep #(
        .H_ACTIVE(2), .V_ACTIVE(2), .NUM_LAYERS(1), .X_W(1), .Y_W(1), .L_W(1)
    ) dut_b (
        .clk_in(clk), .reset_in(rst), .frame_go(go_b), .busy(busy_b),
        .frame_done(done_b), .frame_count(cnt_b), .tok(if_b)
    );

    // Packed view of each stream: {x, y, layer, first, last_layer, last_pixel}.
    logic [26:0] tok_a, tok_b;
    assign tok_a = {8'(if_a.out_x), 8'(if_a.out_y), 8'(if_a.out_layer),
                    if_a.out_first_layer, if_a.out_last_layer, if_a.out_last_pixel};
    assign tok_b = {8'(if_b.out_x), 8'(if_b.out_y), 8'(if_b.out_layer),
                    if_b.out_first_layer, if_b.out_last_layer, if_b.out_last_pixel};

    function automatic logic [26:0] exp_a(input int idx);
        int x, y, l;
        l = idx % 2;
        x = (idx / 2) % 4;
        y = idx / 8;
        return {8'(x), 8'(y), 8'(l), (l == 0), (l == 1), (idx == 23)};
    endfunction

    function automatic logic [26:0] exp_b(input int idx);
        int x, y;
        x = idx % 2;
        y = idx / 2;
        return {8'(x), 8'(y), 8'd0, 1'b1, 1'b1, (idx == 3)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        go_a = 1'b0;
        go_b = 1'b0;
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, cnt_a, if_a.out_valid, tok_a} !== '0) begin
            errors++;
            $display("FAIL reset_a got=%h want=0", {busy_a, done_a, cnt_a, if_a.out_valid, tok_a});
        end
        checks++;
        if ({busy_b, done_b, cnt_b, if_b.out_valid, tok_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0", {busy_b, done_b, cnt_b, if_b.out_valid, tok_b});
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({busy_a, done_a, cnt_a, if_a.out_valid, tok_a} !== '0) begin
                errors++;
                $display("FAIL idle_a got=%h want=0", {busy_a, done_a, cnt_a, if_a.out_valid, tok_a});
            end
        end
    endtask

    task automatic test_full_sweep();
        int idx = 0;
        int cyc = 0;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        while (idx < 24 && cyc < 60) begin
            checks++;
            if (if_a.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_valid idx=%0d got=%b want=1", idx, if_a.out_valid);
            end else begin
                checks++;
                if (tok_a !== exp_a(idx)) begin
                    errors++;
                    $display("FAIL sweep_token idx=%0d got=%h want=%h", idx, tok_a, exp_a(idx));
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({if_a.out_valid, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL sweep_end tokens=%0d got v/b/d/cnt=%b%b%b/%0d want 001/1",
                     idx, if_a.out_valid, busy_a, done_a, cnt_a);
        end
        @(negedge clk);
        checks++;
        if ({done_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL sweep_done_pulse got d/b=%b%b want=00", done_a, busy_a);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        while (idx < 24 && cyc < 60) begin
            checks++;
            if (if_a.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid idx=%0d got=%b want=1", idx, if_a.out_valid);
            end else begin
                checks++;
                if (tok_a !== exp_a(idx)) begin
                    errors++;
                    $display("FAIL bp_token idx=%0d got=%h want=%h", idx, tok_a, exp_a(idx));
                end
                if (idx == 5 && !stalled) begin
                    stalled = 1'b1;
                    if_a.out_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        cyc++;
                        checks++;
                        if (if_a.out_valid !== 1'b1 || tok_a !== exp_a(5)) begin
                            errors++;
                            $display("FAIL bp_hold got v=%b tok=%h want v=1 tok=%h",
                                     if_a.out_valid, tok_a, exp_a(5));
                        end
                    end
                    if_a.out_ready = 1'b1;
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({if_a.out_valid, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b1, 16'd2}) begin
            errors++;
            $display("FAIL bp_end tokens=%0d got v/b/d/cnt=%b%b%b/%0d want 001/2",
                     idx, if_a.out_valid, busy_a, done_a, cnt_a);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int idx = 0;
        int cyc = 0;
        go_a = 1'b1;
        @(negedge clk);
        while (idx < 24 && cyc < 60) begin
            checks++;
            if (if_a.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ign_valid idx=%0d got=%b want=1", idx, if_a.out_valid);
            end else begin
                checks++;
                if (tok_a !== exp_a(idx)) begin
                    errors++;
                    $display("FAIL ign_token idx=%0d got=%h want=%h", idx, tok_a, exp_a(idx));
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({if_a.out_valid, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b1, 16'd3}) begin
            errors++;
            $display("FAIL ign_end got v/b/d/cnt=%b%b%b/%0d want 001/3",
                     if_a.out_valid, busy_a, done_a, cnt_a);
        end
        @(negedge clk);
        checks++;
        if ({if_a.out_valid, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL ign_done_cycle got v/b/d/cnt=%b%b%b/%0d want 000/3",
                     if_a.out_valid, busy_a, done_a, cnt_a);
        end
        @(negedge clk);
        checks++;
        if ({if_a.out_valid, busy_a} !== 2'b11 || tok_a !== exp_a(0)) begin
            errors++;
            $display("FAIL ign_restart got v/b=%b%b tok=%h want 11 tok=%h",
                     if_a.out_valid, busy_a, tok_a, exp_a(0));
        end
        go_a = 1'b0;
        cyc = 0;
        while (done_a !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done_a !== 1'b1 || cnt_a !== 16'd4) begin
            errors++;
            $display("FAIL ign_second_frame got d=%b cnt=%0d want d=1 cnt=4", done_a, cnt_a);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int idx = 0;
        int cyc = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        while (idx < 10 && cyc < 40) begin
            checks++;
            if (if_a.out_valid !== 1'b1 || tok_a !== exp_a(idx)) begin
                errors++;
                $display("FAIL abort_pre idx=%0d got v=%b tok=%h want v=1 tok=%h",
                         idx, if_a.out_valid, tok_a, exp_a(idx));
            end
            idx++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (tok_a !== exp_a(10)) begin
            errors++;
            $display("FAIL abort_tok10 got=%h want=%h", tok_a, exp_a(10));
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, cnt_a, if_a.out_valid, tok_a} !== '0) begin
            errors++;
            $display("FAIL abort_async got=%h want=0", {busy_a, done_a, cnt_a, if_a.out_valid, tok_a});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({busy_a, done_a, cnt_a, if_a.out_valid, tok_a} !== '0) begin
                errors++;
                $display("FAIL abort_idle got=%h want=0", {busy_a, done_a, cnt_a, if_a.out_valid, tok_a});
            end
        end
        idx = 0;
        cyc = 0;
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        while (idx < 24 && cyc < 60) begin
            checks++;
            if (if_a.out_valid !== 1'b1 || tok_a !== exp_a(idx)) begin
                errors++;
                $display("FAIL abort_rerun idx=%0d got v=%b tok=%h want v=1 tok=%h",
                         idx, if_a.out_valid, tok_a, exp_a(idx));
            end
            idx++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({if_a.out_valid, busy_a, done_a, cnt_a} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL abort_end got v/b/d/cnt=%b%b%b/%0d want 001/1",
                     if_a.out_valid, busy_a, done_a, cnt_a);
        end
        @(negedge clk);
    endtask

    task automatic test_single_layer();
        int idx = 0;
        int cyc = 0;
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        while (idx < 4 && cyc < 20) begin
            checks++;
            if (if_b.out_valid !== 1'b1 || tok_b !== exp_b(idx)) begin
                errors++;
                $display("FAIL single_token idx=%0d got v=%b tok=%h want v=1 tok=%h",
                         idx, if_b.out_valid, tok_b, exp_b(idx));
            end
            idx++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({if_b.out_valid, busy_b, done_b, cnt_b} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL single_end got v/b/d/cnt=%b%b%b/%0d want 001/1",
                     if_b.out_valid, busy_b, done_b, cnt_b);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_single_layer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
